// File: rtl/tcm_param_if.sv
// tcm_param_if
//   Bundles every handshake/bus signal of the tightly coupled memory:
//   the instruction read port (ir_*), the data read/write port (d_*) and
//   the auto-load fetch port towards the instruction AHB master (al_*).
//   Modports:
//     slave  - the memory side (tcm_param): answers ir/d requests and drives
//              the fetch request towards the AHB.
//     master - the core/AHB side: issues ir/d requests and answers fetches.
//   Clock and reset are not part of the bundle.
interface tcm_param_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  // instruction read port
  logic                  ir_access;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic [DATA_WIDTH-1:0] ir_rdata;
  logic                  ir_rvalid;

  // data read/write port
  logic                  d_ready;
  logic                  d_access;
  logic                  d_wr;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [NB-1:0]         d_strobe;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_rvalid;
  logic                  d_err;

  // auto-load engine
  logic                  al_start;
  logic                  al_req;
  logic [ADDR_WIDTH-1:0] al_addr;
  logic                  al_ready;
  logic [DATA_WIDTH-1:0] al_rdata;
  logic                  al_rvalid;
  logic                  al_busy;
  logic                  al_done;

  modport slave (
    input  ir_access, ir_addr,
    output ir_rdata, ir_rvalid,
    output d_ready,
    input  d_access, d_wr, d_addr, d_strobe, d_wdata,
    output d_rdata, d_rvalid, d_err,
    input  al_start,
    output al_req, al_addr,
    input  al_ready, al_rdata, al_rvalid,
    output al_busy, al_done
  );

  modport master (
    output ir_access, ir_addr,
    input  ir_rdata, ir_rvalid,
    input  d_ready,
    output d_access, d_wr, d_addr, d_strobe, d_wdata,
    input  d_rdata, d_rvalid, d_err,
    output al_start,
    input  al_req, al_addr,
    output al_ready, al_rdata, al_rvalid,
    input  al_busy, al_done
  );
endinterface

// File: rtl/tcm_param.sv
// tcm_param
//   Parametrised tightly coupled memory (ITCM or DTCM) with:
//     - an instruction read port (1-cycle latency),
//     - a data read/write port with byte strobes (1-cycle read latency),
//     - an auto-load engine that fills the array from the instruction AHB
//       master after reset or on al_start, keeping up to MAX_OUTST fetches
//       in flight and expecting in-order returns.
//   Ports:
//     clk   - clock
//     rstn  - asynchronous active-low reset
//     bus   - tcm_param_if.slave: ir_*, d_*, al_* signal groups
//   Addressing: index = (addr - BASE_ADDR) >> log2(NB); an access is in range
//   when (addr - BASE_ADDR) < DEPTH*NB, compared unsigned, so addresses below
//   BASE_ADDR wrap to large offsets and are rejected.
module tcm_param #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           DEPTH          = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           AUTOLOAD_WORDS = DEPTH,
  parameter int unsigned           MAX_OUTST      = 2
) (
  input  logic       clk,
  input  logic       rstn,
  tcm_param_if.slave bus
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LB = $clog2(NB);
  // One extra bit so that a full-depth load count does not wrap to zero.
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  localparam logic [ADDR_WIDTH:0] SPAN      = (ADDR_WIDTH + 1)'(DEPTH * NB);
  localparam logic [CW-1:0]       AL_WORDS  = CW'(AUTOLOAD_WORDS);
  localparam logic [OW-1:0]       OUTST_MAX = OW'(MAX_OUTST);
  localparam bit                  AL_EN     = (AUTOLOAD_WORDS != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] ir_off;
  logic [ADDR_WIDTH-1:0] d_off;
  logic                  ir_inr;
  logic                  d_inr;
  logic [AW-1:0]         ir_idx;
  logic [AW-1:0]         d_idx;

  assign ir_off = bus.ir_addr - BASE_ADDR;
  assign d_off  = bus.d_addr - BASE_ADDR;
  assign ir_inr = ({1'b0, ir_off} < SPAN);
  assign d_inr  = ({1'b0, d_off} < SPAN);
  assign ir_idx = ir_off[LB +: AW];
  assign d_idx  = d_off[LB +: AW];

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         returned_q, returned_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  al_req_q, al_req_d;
  logic [ADDR_WIDTH-1:0] al_addr_q, al_addr_d;
  logic                  al_busy_q, al_busy_d;
  logic                  al_done_q, al_done_d;

  logic                  ir_rvalid_q, ir_rvalid_d;
  logic                  ir_zero_q, ir_zero_d;
  logic [NB-1:0]         ir_fwd_strb_q, ir_fwd_strb_d;
  logic [DATA_WIDTH-1:0] ir_fwd_data_q, ir_fwd_data_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic                  d_zero_q, d_zero_d;
  logic                  d_err_q, d_err_d;

  // ---------------------------------------------------------------------
  // Port acceptance and the single array write port
  // ---------------------------------------------------------------------
  logic                  ir_acc;
  logic                  d_acc;
  logic                  d_rd;
  logic                  d_we;
  logic                  al_acc;
  logic                  al_ret;
  logic                  mem_we;
  logic [AW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]         w_strb;

  // Both user ports are frozen while the engine owns the array.
  assign ir_acc = bus.ir_access & ~al_busy_q;
  assign d_acc  = bus.d_access & ~al_busy_q;
  assign d_rd   = d_acc & ~bus.d_wr;
  assign d_we   = d_acc & bus.d_wr & d_inr;

  assign al_acc = al_req_q & bus.al_ready;
  // Returns outside LOAD/DRAIN are strays and never touch the array.
  assign al_ret = bus.al_rvalid & al_busy_q;

  // d_we can only be set when not busy and al_ret only when busy, so the
  // mux never has to arbitrate; the fetched word wins by construction.
  assign mem_we = al_ret | d_we;
  assign w_idx  = al_ret ? returned_q[AW-1:0] : d_idx;
  assign w_data = al_ret ? bus.al_rdata : bus.d_wdata;
  assign w_strb = al_ret ? {NB{1'b1}} : bus.d_strobe;

  // ---------------------------------------------------------------------
  // Auto-load engine next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    outst_d    = outst_q;
    al_done_d  = al_done_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.al_start && AL_EN) begin
          issued_d   = '0;
          returned_d = '0;
          outst_d    = '0;
          al_done_d  = 1'b0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD, ST_DRAIN: begin
        if (al_acc) begin
          issued_d = issued_q + 1'b1;
        end
        if (al_ret) begin
          returned_d = returned_q + 1'b1;
        end
        // Accept and return in the same cycle leave the count unchanged.
        if (al_acc && !al_ret) begin
          outst_d = outst_q + 1'b1;
        end else if (!al_acc && al_ret && (outst_q != '0)) begin
          outst_d = outst_q - 1'b1;
        end
        if ((state_q == ST_LOAD) && al_acc && (issued_d == AL_WORDS)) begin
          state_d = ST_DRAIN;
        end
        if ((state_q == ST_DRAIN) && al_ret && (returned_d == AL_WORDS)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_DONE) begin
      al_done_d = 1'b1;
    end

    // Outputs are computed from the next-state values so the registered
    // request reflects the counters exactly as they will stand next cycle;
    // this is what keeps the in-flight count from ever exceeding MAX_OUTST.
    al_busy_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    al_req_d  = (state_d == ST_LOAD) && (issued_d < AL_WORDS) &&
                (outst_d < OUTST_MAX);
    al_addr_d = BASE_ADDR + (ADDR_WIDTH'(issued_d) << LB);
  end

  // ---------------------------------------------------------------------
  // Read-side next state
  // ---------------------------------------------------------------------
  always_comb begin
    ir_rvalid_d   = ir_acc;
    ir_zero_d     = ir_zero_q;
    ir_fwd_strb_d = ir_fwd_strb_q;
    ir_fwd_data_d = ir_fwd_data_q;
    d_rvalid_d    = d_rd;
    d_zero_d      = d_zero_q;
    d_err_d       = d_acc & ~d_inr;

    // Response qualifiers only move on an accepted access, so rdata is
    // held until the next valid.
    if (ir_acc) begin
      ir_zero_d     = ~ir_inr;
      // The array read sees the old word; remember which bytes the
      // concurrent data write replaces so the response is the merged word.
      ir_fwd_strb_d = (d_we && ir_inr && (ir_idx == d_idx)) ? bus.d_strobe : '0;
      ir_fwd_data_d = bus.d_wdata;
    end
    // A data read never coincides with a write: the data port carries one
    // operation per cycle and fetch writes only happen while it is blocked.
    if (d_rd) begin
      d_zero_d = ~d_inr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= AL_EN ? ST_LOAD : ST_IDLE;
      issued_q      <= '0;
      returned_q    <= '0;
      outst_q       <= '0;
      al_req_q      <= 1'b0;
      al_addr_q     <= '0;
      al_busy_q     <= AL_EN;
      al_done_q     <= 1'b0;
      ir_rvalid_q   <= 1'b0;
      ir_zero_q     <= 1'b1;
      ir_fwd_strb_q <= '0;
      ir_fwd_data_q <= '0;
      d_rvalid_q    <= 1'b0;
      d_zero_q      <= 1'b1;
      d_err_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      returned_q    <= returned_d;
      outst_q       <= outst_d;
      al_req_q      <= al_req_d;
      al_addr_q     <= al_addr_d;
      al_busy_q     <= al_busy_d;
      al_done_q     <= al_done_d;
      ir_rvalid_q   <= ir_rvalid_d;
      ir_zero_q     <= ir_zero_d;
      ir_fwd_strb_q <= ir_fwd_strb_d;
      ir_fwd_data_q <= ir_fwd_data_d;
      d_rvalid_q    <= d_rvalid_d;
      d_zero_q      <= d_zero_d;
      d_err_q       <= d_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Storage: one byte-wide array per strobe lane with registered reads.
  // Read registers are not reset; the *_zero_q flags mask them until the
  // first in-range read.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ir_merged;
  logic [DATA_WIDTH-1:0] d_ram;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] ir_byte_q;
      logic [7:0] d_byte_q;

      always_ff @(posedge clk) begin
        if (mem_we && w_strb[gi]) begin
          lane_mem[w_idx] <= w_data[gi*8 +: 8];
        end
        if (ir_acc) begin
          ir_byte_q <= lane_mem[ir_idx];
        end
        if (d_rd) begin
          d_byte_q <= lane_mem[d_idx];
        end
      end

      assign ir_merged[gi*8 +: 8] = ir_fwd_strb_q[gi] ? ir_fwd_data_q[gi*8 +: 8]
                                                      : ir_byte_q;
      assign d_ram[gi*8 +: 8]     = d_byte_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.ir_rvalid = ir_rvalid_q;
  assign bus.ir_rdata  = ir_zero_q ? '0 : ir_merged;
  assign bus.d_ready   = ~al_busy_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_zero_q ? '0 : d_ram;
  assign bus.d_err     = d_err_q;
  assign bus.al_req    = al_req_q;
  assign bus.al_addr   = al_addr_q;
  assign bus.al_busy   = al_busy_q;
  assign bus.al_done   = al_done_q;

endmodule
